// File: rtl/vdec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vdec_pkg
// Description : Shared opcodes, instruction field positions and scalar-select
//               constants for the vector decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
package vdec_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_VADD = 4'd1,
    OP_VMUL = 4'd2,
    OP_VLD  = 4'd3,
    OP_VST  = 4'd4,
    OP_SLI  = 4'd5,
    OP_SINC = 4'd6
  } opcode_e;

  // Instruction field LSB positions
  localparam int c_OP_LSB  = 28;
  localparam int c_VD_LSB  = 24;
  localparam int c_VS1_LSB = 20;
  localparam int c_VS2_LSB = 16;
  localparam int c_IMM_W   = 16;

  // Scalar loop register select taken from vd[1:0]
  localparam logic [1:0] c_SEL_I = 2'd0;
  localparam logic [1:0] c_SEL_J = 2'd1;
  localparam logic [1:0] c_SEL_N = 2'd2;

  // Opcodes 7..15 are not defined
  function automatic logic is_legal(input logic [3:0] op);
    return op <= 4'd6;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vdec_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : vdec_scoreboard
// Description : Pending-write bits for the vector register file. One set and
//               one clear port; set wins when both hit the same register.
//               Answers a hazard query for three addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module vdec_scoreboard #(
  parameter int NVREG = 16,
  parameter int AW    = $clog2(NVREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [AW-1:0]   set_addr,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_addr,
  input  logic [3*AW-1:0] q_addr,
  input  logic [2:0]      q_en,
  output logic            hazard,
  output logic            busy
);

  logic [NVREG-1:0] r_pend;
  logic [2:0]       w_hit;

  // One pending flop per register; set takes priority over clear
  for (genvar k = 0; k < NVREG; k++) begin : g_bit
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_pend[k] <= 1'b0;
      end else if (set_en && (set_addr == AW'(k))) begin
        r_pend[k] <= 1'b1;
      end else if (clr_en && (clr_addr == AW'(k))) begin
        r_pend[k] <= 1'b0;
      end
    end
  end

  // Each enabled query address conflicts if its register is pending
  for (genvar q = 0; q < 3; q++) begin : g_query
    assign w_hit[q] = q_en[q] && r_pend[q_addr[q*AW +: AW]];
  end

  assign hazard = |w_hit;
  assign busy   = |r_pend;

endmodule
`default_nettype wire

// File: rtl/vec_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : vec_decode_stage
// Description : Vector ASIP decode stage. Decodes one instruction per cycle,
//               reads two source vectors, tracks pending writes, runs scalar
//               loop ops locally and issues vector ops over valid/ready.
//               Optional macro VDEC_BYPASS_EN forwards write-back data into
//               the operand path and drops the forwarded register from the
//               hazard check in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_decode_stage
  import vdec_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DW    = 32,
  parameter int NVREG = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                instr,
  input  logic                       wb_valid,
  input  logic [$clog2(NVREG)-1:0]   wb_addr,
  input  logic [LANES*DW-1:0]        wb_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 out_op,
  output logic [$clog2(NVREG)-1:0]   out_vd,
  output logic [LANES*DW-1:0]        out_a,
  output logic [LANES*DW-1:0]        out_b,
  output logic [DW-1:0]              out_imm,
  output logic                       out_wr_vreg,
  output logic                       out_wr_mem,
  output logic [DW-1:0]              i,
  output logic [DW-1:0]              j,
  output logic [DW-1:0]              n,
  output logic                       busy,
  output logic                       illegal
);

  localparam int AW = $clog2(NVREG);
  localparam int VW = LANES * DW;

  logic [3:0]         w_op;
  logic [AW-1:0]      w_vd;
  logic [AW-1:0]      w_vs1;
  logic [AW-1:0]      w_vs2;
  logic [c_IMM_W-1:0] w_imm;
  logic [1:0]         w_sel;
  logic               w_rd1;
  logic               w_rd2;
  logic               w_wrv;
  logic               w_wrm;
  logic               w_vec;
  logic               w_byp1;
  logic               w_byp2;
  logic               w_bypd;
  logic               w_hazard;
  logic               w_acc;
  logic [VW-1:0]      w_a;
  logic [VW-1:0]      w_b;
  logic [DW-1:0]      w_inc_i;
  logic [DW-1:0]      w_inc_j;

  logic [VW-1:0]      r_vreg [NVREG];

  assign w_op  = instr[c_OP_LSB  +: 4];
  assign w_vd  = instr[c_VD_LSB  +: AW];
  assign w_vs1 = instr[c_VS1_LSB +: AW];
  assign w_vs2 = instr[c_VS2_LSB +: AW];
  assign w_imm = instr[c_IMM_W-1:0];
  assign w_sel = instr[c_VD_LSB  +: 2];

  // Per-opcode source usage and write targets
  always_comb begin
    w_rd1 = (w_op == OP_VADD) || (w_op == OP_VMUL) || (w_op == OP_VST);
    w_rd2 = (w_op == OP_VADD) || (w_op == OP_VMUL);
    w_wrv = (w_op == OP_VADD) || (w_op == OP_VMUL) || (w_op == OP_VLD);
    w_wrm = (w_op == OP_VST);
    w_vec = w_rd1 || w_wrv;
  end

`ifdef VDEC_BYPASS_EN
  assign w_byp1 = wb_valid && (wb_addr == w_vs1);
  assign w_byp2 = wb_valid && (wb_addr == w_vs2);
  assign w_bypd = wb_valid && (wb_addr == w_vd);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
  assign w_bypd = 1'b0;
`endif

  vdec_scoreboard #(
    .NVREG (NVREG),
    .AW    (AW)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (w_acc && w_wrv),
    .set_addr (w_vd),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .q_addr   ({w_vd, w_vs2, w_vs1}),
    .q_en     ({w_wrv && !w_bypd, w_rd2 && !w_byp2, w_rd1 && !w_byp1}),
    .hazard   (w_hazard),
    .busy     (busy)
  );

  assign in_ready = (!out_valid || out_ready) && !w_hazard;
  assign w_acc    = in_valid && in_ready;

  // Forwarded operands only differ from the array read when bypass is built in
  assign w_a = w_byp1 ? wb_data : r_vreg[w_vs1];
  assign w_b = w_byp2 ? wb_data : r_vreg[w_vs2];

  // Register file: write-back port only, cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NVREG; k++) r_vreg[k] <= '0;
    end else if (wb_valid) begin
      r_vreg[wb_addr] <= wb_data;
    end
  end

  // Output register: load on vector accept, drop valid once execute takes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_op      <= '0;
      out_vd      <= '0;
      out_a       <= '0;
      out_b       <= '0;
      out_imm     <= '0;
      out_wr_vreg <= 1'b0;
      out_wr_mem  <= 1'b0;
    end else if (w_acc && w_vec) begin
      out_valid   <= 1'b1;
      out_op      <= w_op;
      out_vd      <= w_vd;
      out_imm     <= DW'(w_imm);
      out_wr_vreg <= w_wrv;
      out_wr_mem  <= w_wrm;
      if (w_rd1) out_a <= w_a;
      if (w_rd2) out_b <= w_b;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  assign w_inc_i = i + DW'(1);
  assign w_inc_j = j + DW'(1);

  // Scalar loop registers; i and j wrap to zero on reaching n
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i <= '0;
      j <= '0;
      n <= '0;
    end else if (w_acc && (w_op == OP_SLI)) begin
      case (w_sel)
        c_SEL_I: i <= DW'(w_imm);
        c_SEL_J: j <= DW'(w_imm);
        c_SEL_N: n <= DW'(w_imm);
        default: ;
      endcase
    end else if (w_acc && (w_op == OP_SINC)) begin
      case (w_sel)
        c_SEL_I: i <= (w_inc_i == n) ? '0 : w_inc_i;
        c_SEL_J: j <= (w_inc_j == n) ? '0 : w_inc_j;
        c_SEL_N: n <= n + DW'(1);
        default: ;
      endcase
    end
  end

  // Sticky illegal-opcode flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal <= 1'b0;
    end else if (w_acc && !is_legal(w_op)) begin
      illegal <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vec_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_decode_stage
// Description : Directed self-checking bench for vec_decode_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_decode_stage;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  instr;
  logic         wb_valid;
  logic [3:0]   wb_addr;
  logic [127:0] wb_data;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_op;
  logic [3:0]   out_vd;
  logic [127:0] out_a;
  logic [127:0] out_b;
  logic [31:0]  out_imm;
  logic         out_wr_vreg;
  logic         out_wr_mem;
  logic [31:0]  i;
  logic [31:0]  j;
  logic [31:0]  n;
  logic         busy;
  logic         illegal;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] d1;
  logic [127:0] d2;
  logic [127:0] d9;

  vec_decode_stage #(
    .LANES (4),
    .DW    (32),
    .NVREG (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op      (out_op),
    .out_vd      (out_vd),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_imm     (out_imm),
    .out_wr_vreg (out_wr_vreg),
    .out_wr_mem  (out_wr_mem),
    .i           (i),
    .j           (j),
    .n           (n),
    .busy        (busy),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc(input int op, input int vd, input int vs1,
                                      input int vs2, input int imm);
    logic [31:0] r;
    r = {op[3:0], vd[3:0], vs1[3:0], vs2[3:0], imm[15:0]};
    return r;
  endfunction

  initial begin
    d1 = 128'h11111111_22222222_33333333_44444444;
    d2 = 128'hAAAA0000_BBBB0000_CCCC0000_DDDD0000;
    d9 = 128'h90909090_80808080_70707070_60606060;
    rst       = 1'b0;
    in_valid  = 1'b0;
    instr     = '0;
    wb_valid  = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    out_ready = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_i", i, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_out_a", out_a, 0);
    #10 rst = 1'b1;
    tick();

    // Scalar loop ops: n=3, i=0, then four increments
    in_valid = 1'b1;
    instr = enc(5, 2, 0, 0, 3);
    #1 chk("sli_ready", in_ready, 1);
    tick();
    chk("sli_n", n, 3);
    instr = enc(5, 0, 0, 0, 0);
    tick();
    chk("sli_i", i, 0);
    instr = enc(6, 0, 0, 0, 0);
    tick(); chk("sinc1", i, 1); chk("sinc1_nov", out_valid, 0);
    tick(); chk("sinc2", i, 2); chk("sinc2_nov", out_valid, 0);
    tick(); chk("sinc3", i, 0); chk("sinc3_nov", out_valid, 0);
    tick(); chk("sinc4", i, 1); chk("sinc4_nov", out_valid, 0);
    in_valid = 1'b0;

    // Preload v1 through write-back
    wb_valid = 1'b1; wb_addr = 4'd1; wb_data = d1;
    tick();
    wb_valid = 1'b0;
    chk("wb1_busy", busy, 0);

    // VLD v2
    in_valid = 1'b1;
    instr = enc(3, 2, 0, 0, 16'h1234);
    tick();
    chk("vld_valid", out_valid, 1);
    chk("vld_op", out_op, 3);
    chk("vld_vd", out_vd, 2);
    chk("vld_wrv", out_wr_vreg, 1);
    chk("vld_wrm", out_wr_mem, 0);
    chk("vld_imm", out_imm, 32'h1234);
    chk("vld_busy", busy, 1);

    // VADD v3,v2,v1 stalls on v2
    instr = enc(1, 3, 2, 1, 0);
    #1 chk("raw_stall", in_ready, 0);
    tick();
    chk("raw_noissue", out_valid, 0);
    chk("raw_stall2", in_ready, 0);
    wb_valid = 1'b1; wb_addr = 4'd2; wb_data = d2;
`ifdef VDEC_BYPASS_EN
    #1 chk("byp_ready", in_ready, 1);
    tick();
    wb_valid = 1'b0;
`else
    #1 chk("nobyp_ready", in_ready, 0);
    tick();
    wb_valid = 1'b0;
    chk("nobyp_noissue", out_valid, 0);
    #1 chk("nobyp_ready2", in_ready, 1);
    tick();
`endif
    chk("vadd_valid", out_valid, 1);
    chk("vadd_op", out_op, 1);
    chk("vadd_a", out_a, d2);
    chk("vadd_b", out_b, d1);
    chk("vadd_busy", busy, 1);

    // VMUL v4 issues, then is held three cycles
    instr = enc(2, 4, 1, 1, 0);
    tick();
    chk("vmul_vd", out_vd, 4);
    out_ready = 1'b0;
    instr = enc(2, 6, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      #1 chk("hold_ready", in_ready, 0);
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_vd", out_vd, 4);
      chk("hold_op", out_op, 2);
      chk("hold_a", out_a, d1);
    end
    out_ready = 1'b1;
    #1 chk("release_ready", in_ready, 1);
    tick();
    chk("b2b_vd6", out_vd, 6);
    instr = enc(1, 7, 1, 1, 0);
    tick();
    chk("b2b_vd7", out_vd, 7);
    chk("b2b_op", out_op, 1);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", out_valid, 0);

    // Retire pending 3,4,6,7
    wb_valid = 1'b1; wb_data = '0;
    wb_addr = 4'd3; tick();
    wb_addr = 4'd4; tick();
    wb_addr = 4'd6; tick();
    wb_addr = 4'd7; tick();
    wb_valid = 1'b0;
    chk("retire_busy", busy, 0);

    // Issue VLD v5 while v5 is written back: set wins
    in_valid = 1'b1;
    instr = enc(3, 5, 0, 0, 0);
    wb_valid = 1'b1; wb_addr = 4'd5; wb_data = d2;
    tick();
    wb_valid = 1'b0;
    chk("setwins_busy", busy, 1);
    instr = enc(1, 8, 5, 1, 0);
    #1 chk("setwins_stall", in_ready, 0);
    in_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 4'd5; wb_data = d2;
    tick();
    wb_valid = 1'b0;
    chk("v5_clear", busy, 0);

    // Illegal opcode, then VST accepted normally
    in_valid = 1'b1;
    instr = enc(9, 0, 0, 0, 0);
    tick();
    chk("ill_flag", illegal, 1);
    chk("ill_noissue", out_valid, 0);
    instr = enc(4, 0, 1, 0, 0);
    #1 chk("post_ill_ready", in_ready, 1);
    tick();
    chk("vst_valid", out_valid, 1);
    chk("vst_wrm", out_wr_mem, 1);
    chk("vst_wrv", out_wr_vreg, 0);
    chk("vst_a", out_a, d1);
    chk("ill_sticky", illegal, 1);
    chk("vst_busy", busy, 0);

    // Mid-stream asynchronous reset
    instr = enc(3, 9, 0, 0, 0);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_i", i, 0);
    chk("arst_n", n, 0);
    chk("arst_illegal", illegal, 0);
    #1 rst = 1'b1;

    // Late write-back after reset is still written
    wb_valid = 1'b1; wb_addr = 4'd9; wb_data = d9;
    tick();
    wb_valid = 1'b0;
    in_valid = 1'b1;
    instr = enc(4, 0, 9, 0, 0);
    tick();
    in_valid = 1'b0;
    chk("late_wb_a", out_a, d9);
    chk("late_wb_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
